// File: rtl/bcd_pkg.sv
// Shared BCD definitions: FSM encodings and digit constants, common to the
// BCD-to-binary decoder and the binary-to-BCD encoder.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [3:0] DD_THRESHOLD  = 4'd8;
  localparam logic [3:0] DD_CORRECTION = 4'd3;

  function automatic logic digit_is_bcd(input logic [3:0] digit);
    return (digit <= BCD_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_to_binary_converter_if.sv
// Request/response bundle of the BCD-to-binary converter.
interface bcd_to_binary_converter_if #(
  parameter int NUM_DIGITS = 2,
  parameter int BIN_WIDTH  = 7
);

  logic                    start;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    busy;
  logic                    done;
  logic [BIN_WIDTH-1:0]    bin_out;
  logic                    error;

  modport master (
    output start,
    output bcd_in,
    input  busy,
    input  done,
    input  bin_out,
    input  error
  );

  modport slave (
    input  start,
    input  bcd_in,
    output busy,
    output done,
    output bin_out,
    output error
  );

endinterface

// File: rtl/bcd_digit_correct.sv
// Reverse double-dabble correction for one BCD digit: subtract 3 when >= 8.
module bcd_digit_correct
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Per-digit correction, no borrow leaves the nibble
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= DD_THRESHOLD) begin
      digit_o = digit_i - DD_CORRECTION;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/bcd_to_binary_converter.sv
// Sequential packed-BCD to binary decoder (reverse double-dabble, one shift
// per cycle) with start/busy/done handshake and invalid-digit flag.
module bcd_to_binary_converter
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int BIN_WIDTH  = 7
) (
  input  logic                     CLK_50M,
  input  logic                     RST_N,
  bcd_to_binary_converter_if.slave bus
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SR_W  = BCD_W + BIN_WIDTH;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_WIDTH - 1);

  state_e               state_q,    state_d;
  logic [BCD_W-1:0]     bcd_sr_q,   bcd_sr_d;
  logic [BIN_WIDTH-1:0] bin_sr_q,   bin_sr_d;
  logic [CNT_W-1:0]     cnt_q,      cnt_d;
  logic                 err_flag_q, err_flag_d;
  logic                 busy_q,     busy_d;
  logic                 done_q,     done_d;
  logic [BIN_WIDTH-1:0] bin_out_q,  bin_out_d;
  logic                 error_q,    error_d;

  logic [SR_W-1:0]      shifted_s;
  logic [BCD_W-1:0]     shift_bcd_s;
  logic [BCD_W-1:0]     corr_bcd_s;
  logic [BIN_WIDTH-1:0] shift_bin_s;
  logic                 bad_digit_s;

  assign shifted_s   = {bcd_sr_q, bin_sr_q} >> 1;
  assign shift_bcd_s = shifted_s[SR_W-1:BIN_WIDTH];
  assign shift_bin_s = shifted_s[BIN_WIDTH-1:0];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_corr
    bcd_digit_correct u_corr (
      .digit_i (shift_bcd_s[4*g +: 4]),
      .digit_o (corr_bcd_s[4*g +: 4])
    );
  end

  // Any nibble of the request above 9 rejects the whole request
  always_comb begin
    bad_digit_s = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      bad_digit_s = bad_digit_s | ~digit_is_bcd(bus.bcd_in[4*i +: 4]);
    end
  end

  // Next-state, datapath and output computation
  always_comb begin
    state_d    = state_q;
    bcd_sr_d   = bcd_sr_q;
    bin_sr_d   = bin_sr_q;
    cnt_d      = cnt_q;
    err_flag_d = err_flag_q;
    bin_out_d  = bin_out_q;
    error_d    = error_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bad_digit_s) begin
            err_flag_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            err_flag_d = 1'b0;
            bcd_sr_d   = bus.bcd_in;
            bin_sr_d   = {BIN_WIDTH{1'b0}};
            cnt_d      = {CNT_W{1'b0}};
            state_d    = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        bcd_sr_d = corr_bcd_s;
        bin_sr_d = shift_bin_s;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Results are published on the edge that enters DONE, alongside done
    if (state_d == ST_DONE) begin
      done_d    = 1'b1;
      error_d   = err_flag_d;
      bin_out_d = err_flag_d ? {BIN_WIDTH{1'b0}} : bin_sr_d;
    end else begin
      done_d    = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      bcd_sr_q   <= {BCD_W{1'b0}};
      bin_sr_q   <= {BIN_WIDTH{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      err_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bin_out_q  <= {BIN_WIDTH{1'b0}};
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd_sr_q   <= bcd_sr_d;
      bin_sr_q   <= bin_sr_d;
      cnt_q      <= cnt_d;
      err_flag_q <= err_flag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bin_out_q  <= bin_out_d;
      error_q    <= error_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bin_out = bin_out_q;
  assign bus.error   = error_q;

endmodule

// File: tb/tb_bcd_to_binary_converter.sv
// Scoreboard bench for bcd_to_binary_converter: stimulus pushes expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_bcd_to_binary_converter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  bcd_to_binary_converter_if #(.NUM_DIGITS(2), .BIN_WIDTH(7)) bus ();

  bcd_to_binary_converter #(.NUM_DIGITS(2), .BIN_WIDTH(7)) dut (
    .CLK_50M (clk),
    .RST_N   (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int   bin;
    logic err;
    int   acc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int b, input logic e);
    exp_t x;
    x.bin = b;
    x.err = e;
    x.acc = cyc;
    sb_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      check("done_width", int'(done_prev), 0);
      check("busy_with_done", int'(bus.busy), 1);
      if (sb_q.size() == 0) begin
        check("unexpected_done", sb_q.size(), 1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("bin_out", int'(bus.bin_out), e.bin);
        check("error", int'(bus.error), int'(e.err));
        check("latency", cyc - e.acc, e.err ? 0 : 7);
        if (!e.err) check("bcd_sr_zero", int'(dut.bcd_sr_q), 0);
      end
    end
    done_prev <= bus.done;
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) check("idle_timeout", int'(bus.busy), 0);
  endtask

  task automatic convert(input logic [7:0] v, input int exp_bin, input logic exp_err);
    wait_idle();
    bus.start  = 1'b1;
    bus.bcd_in = v;
    @(posedge clk);
    #1;
    push_exp(exp_bin, exp_err);
    check("busy_after_start", int'(bus.busy), 1);
    bus.start  = 1'b0;
    bus.bcd_in = 8'hFF;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},    int'(bus.busy),    0);
    check({tag, "_done"},    int'(bus.done),    0);
    check({tag, "_bin_out"}, int'(bus.bin_out), 0);
    check({tag, "_error"},   int'(bus.error),   0);
  endtask

  initial begin
    int n;
    bus.start  = 1'b0;
    bus.bcd_in = 8'h00;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    convert(8'h99, 99, 1'b0);
    convert(8'h00, 0,  1'b0);
    convert(8'h47, 47, 1'b0);
    convert(8'h10, 10, 1'b0);
    convert(8'h3A, 0,  1'b1);
    convert(8'h25, 25, 1'b0);
    convert(8'hA0, 0,  1'b1);

    // start held high; bcd_in changes mid-conversion
    wait_idle();
    bus.start  = 1'b1;
    bus.bcd_in = 8'h12;
    @(posedge clk);
    #1;
    push_exp(12, 1'b0);
    repeat (2) @(negedge clk);
    bus.bcd_in = 8'h88;
    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("held_done_seen", int'(bus.done), 1);
    @(posedge clk);
    #1;
    check("held_idle_after_done", int'(bus.busy), 0);
    @(posedge clk);
    #1;
    push_exp(88, 1'b0);
    check("held_second_accept", int'(bus.busy), 1);
    bus.start = 1'b0;

    // reset in the 4th SHIFT cycle
    wait_idle();
    bus.start  = 1'b1;
    bus.bcd_in = 8'h63;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_reset_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    check("midreset_cnt", int'(dut.cnt_q), 0);
    @(negedge clk);
    rst_n = 1'b1;
    convert(8'h63, 63, 1'b0);

    // sweep all valid two-digit codes
    for (int t = 0; t < 10; t++) begin
      for (int u = 0; u < 10; u++) begin
        convert({t[3:0], u[3:0]}, t * 10 + u, 1'b0);
      end
    end
    convert(8'h9F, 0, 1'b1);

    wait_idle();
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary_converter.md
Name: bcd_to_binary_converter

Overview:
- Sequential decoder that takes an NUM_DIGITS-digit packed BCD value, as produced by the team's BCD counters and LED displays, and converts it to plain binary.
- Uses reverse double-dabble: one shift per cycle, per-digit subtract-3 correction.
- Sits between BCD sources (counters, switch inputs) and arithmetic or compare logic that needs binary.
- Start/busy/done handshake; invalid digits are flagged.

Parameters:
- NUM_DIGITS, 2, number of BCD digits on bcd_in.
- BIN_WIDTH, 7, width of bin_out; must satisfy 2^BIN_WIDTH > 10^NUM_DIGITS - 1 (7 bits holds 0..99).

Ports:
- CLK_50M  input  1  system clock, single clock domain, all logic on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bcd_in  input  4*NUM_DIGITS  packed BCD, most significant digit in the MSBs; sampled on the accepted start cycle.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse when bin_out/error are updated.
- bin_out  output  BIN_WIDTH  converted value; holds until the next done.
- error  output  1  high if the last request held a digit > 9; holds until the next done.

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream):
  - state=IDLE, busy=0, done=0, bin_out=0, error=0.
  - Working shift register and iteration counter cleared.
- Internal working register: {bcd_sr[4*NUM_DIGITS-1:0], bin_sr[BIN_WIDTH-1:0]}; counter width ceil(log2(BIN_WIDTH+1)).
- IDLE:
  - busy=0.
  - If start=1, check every digit of bcd_in.
  - Any digit > 9: go to DONE with err_flag=1; no shifting.
  - Otherwise: load bcd_sr=bcd_in, bin_sr=0, cnt=0, go to SHIFT.
- SHIFT, one iteration per cycle:
  - Shift the whole register right by 1; the LSB of bcd_sr enters the MSB of bin_sr.
  - Then, on the shifted value, every 4-bit digit of bcd_sr that is >= 8 has 3 subtracted (4-bit arithmetic; no borrow between digits).
  - cnt increments; when cnt reaches BIN_WIDTH-1 this cycle, next state is DONE.
  - Exactly BIN_WIDTH SHIFT cycles.
- DONE (single cycle):
  - done=1.
  - bin_out is loaded from bin_sr (or 0 when err_flag=1); error=err_flag.
  - Next state IDLE.
- Latency:
  - Valid input: start accepted at edge N; done high during cycle N+BIN_WIDTH+1 (8 cycles for default parameters). bin_out is valid from the same edge as done and stable afterwards.
  - Invalid input: done high in cycle N+1.
- start outside IDLE (SHIFT or DONE) is ignored. There is no queueing; the requester waits for busy=0.
- bcd_in changes after acceptance have no effect on the current conversion.
- Reset mid-conversion: immediate return to the reset values; the partial result is discarded and no done pulse is produced.
- After a valid conversion, bcd_sr is all zeros; the bench may assert this as an internal check.
- A state encoding outside IDLE/SHIFT/DONE recovers to IDLE.

Decomposition:
- Shared package bcd_pkg:
  - State encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - BCD_DIGIT_MAX=4'd9, DD_THRESHOLD=4'd8, DD_CORRECTION=4'd3.
  - Both will be reused by the planned binary-to-BCD encoder.
- One sub-module, bcd_digit_correct: purely combinational, 4-bit in / 4-bit out (subtract 3 if >= 8). Instantiated NUM_DIGITS times with a generate loop.
- The FSM, counter and shift register stay in the top module.

Test Plan:
- Reset, then bcd_in=8'h99, one-cycle start -> busy=1 for 8 cycles; done pulse at cycle 8; bin_out=7'd99; error=0.
- bcd_in=8'h00 -> bin_out=0, error=0; bcd_in=8'h47 -> bin_out=7'd47; bcd_in=8'h10 -> bin_out=7'd10.
- bcd_in=8'h3A, start -> done on the next cycle; error=1; bin_out=0. Then 8'h25 -> error=0, bin_out=25.
- start held high continuously with 8'h12, then bcd_in switched to 8'h88 during SHIFT -> exactly one conversion per IDLE visit; first result 12; the next conversion starts only after done.
- RST_N pulsed low in the 4th SHIFT cycle of 8'h63 -> all outputs 0 immediately; no done; a new start with 8'h63 gives 63.
- Exhaustive sweep 8'h00..8'h99 over valid BCD codes -> bin_out equals the decimal value; done width is always 1 cycle.
